uart_tx_queue: RTL and testbench

//  Byte FIFO and dispatcher that sits directly upstream of the UART transmitter.

---
 rtl/uart_tx_queue.sv | 146 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus one-frame-at-a-time dispatcher in front of the UART transmitter.
// Optional macro UART_TXQ_OVF_STICKY_EN makes overflow sticky until i_ovf_clr.
module uart_tx_queue #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int GAP_TICKS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_tick,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level,
  output logic          o_overflow,
  input  logic          i_ovf_clr,
  output logic          o_tx_start,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_busy,
  output logic [1:0]    o_state
);

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  // Handshake: o_tx_start rises with a new byte on o_tx_data and holds both
  // until i_tx_busy is seen high; the next frame waits for i_tx_busy low plus
  // GAP_TICKS tick pulses.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_GAP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [AW:0]   w_level_nxt;
  logic          r_full;
  logic          r_empty;
  logic [7:0]    r_tx_data;
  logic          r_ovf;
  logic [GW-1:0] r_gap_cnt;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_pop  = (r_state == S_IDLE) & ~r_empty & ~i_tx_busy;
  assign w_push = i_wr_en & (~r_full | w_pop);
  assign w_drop = i_wr_en & r_full & ~w_pop;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + (AW+1)'(1);
    else if (w_pop && !w_push)
      w_level_nxt = r_level - (AW+1)'(1);
  end

  // A push into a full queue during a pop writes the slot being read; the
  // read sees the old byte because both happen on the same edge.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_tx_data <= 8'h00;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_pop) w_state_nxt = S_ISSUE;
      S_ISSUE:     if (i_tx_busy) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!i_tx_busy) w_state_nxt = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
      S_GAP:       if (i_tick && r_gap_cnt == GW'(GAP_TICKS - 1)) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_start = (r_state == S_ISSUE);
    o_state    = r_state;
    o_tx_data  = r_tx_data;
    o_level    = r_level;
    o_full     = r_full;
    o_empty    = r_empty;
    o_overflow = r_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_gap_cnt <= '0;
    else if (r_state == S_WAIT_DONE && !i_tx_busy)
      r_gap_cnt <= '0;
    else if (r_state == S_GAP && i_tick)
      r_gap_cnt <= r_gap_cnt + GW'(1);
  end

`ifdef UART_TXQ_OVF_STICKY_EN
  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (i_ovf_clr)
      r_ovf <= 1'b0;
  end
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = i_ovf_clr;

  always_ff @(posedge clk) begin
    if (rst)
      r_ovf <= 1'b0;
    else
      r_ovf <= w_drop;
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed scenarios plus random traffic against a
// queue-based reference model and a small transmitter model driving tx_busy.
module tb_uart_tx_queue;

  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int GAP_TICKS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          busy = 1'b0;
  logic          o_full;
  logic          o_empty;
  logic [AW:0]   o_level;
  logic          o_overflow;
  logic          o_tx_start;
  logic [7:0]    o_tx_data;
  logic [1:0]    o_state;

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .GAP_TICKS(GAP_TICKS)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (tick),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_level    (o_level),
    .o_overflow (o_overflow),
    .i_ovf_clr  (ovf_clr),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (busy),
    .o_state    (o_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: queue contents plus what the dispatcher is doing
  logic [7:0] exp_q[$];
  logic [7:0] emit_q[$];
  bit         m_start = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_wait = 0;
  int         m_gap_left = 0;
  bit         m_ovf = 0;

  // transmitter model and gap bookkeeping
  bit auto_tx = 0;
  bit stuck = 0;
  bit in_frame = 0;
  int xmit_left = 0;
  int frame_len = 0;
  bit exempt = 0;
  bit fall_pending = 0;
  bit gap_armed = 0;
  int gap_ticks = 0;
  int gap_checks = 0;
  bit prev_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_quiet();
    return (exp_q.size() == 0) && !m_start && !m_wait && (m_gap_left == 0);
  endfunction

  task automatic model_step();
    bit idle;
    bit pop;
    bit drop;
    if (rst) begin
      exp_q.delete();
      m_start = 0; m_data = 8'h00; m_wait = 0; m_gap_left = 0; m_ovf = 0;
    end else begin
      idle = !m_start && !m_wait && (m_gap_left == 0);
      pop  = idle && (exp_q.size() != 0) && !busy;
      drop = wr_en && (exp_q.size() == DEPTH) && !pop;
      if (pop) m_data = exp_q.pop_front();
      if (wr_en && !drop) exp_q.push_back(wr_data);
      if (pop) m_start = 1;
      else if (m_start && busy) begin m_start = 0; m_wait = 1; end
      else if (m_wait && !busy) begin m_wait = 0; m_gap_left = GAP_TICKS; end
      else if (m_gap_left > 0 && tick) m_gap_left--;
`ifdef UART_TXQ_OVF_STICKY_EN
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
`else
      m_ovf = drop;
`endif
    end
  endtask

  // one clock: model update at the edge, compare 1 time unit later
  task automatic cycle();
    @(posedge clk);
    if (fall_pending) begin fall_pending = 0; gap_armed = 1; gap_ticks = 0; end
    else if (gap_armed && tick) gap_ticks++;
    model_step();
    #1;
    check("level", o_level, exp_q.size());
    check("full", o_full, exp_q.size() == DEPTH);
    check("empty", o_empty, exp_q.size() == 0);
    check("tx_start", o_tx_start, m_start);
    check("tx_data", o_tx_data, m_data);
    check("overflow", o_overflow, m_ovf);
    if (rst) begin gap_armed = 0; fall_pending = 0; exempt = in_frame; end
    if (o_tx_start && !prev_start) begin
      emit_q.push_back(o_tx_data);
      if (gap_armed) begin
        gap_checks++;
        check("gap_ticks_before_start", gap_ticks >= GAP_TICKS, 1);
        gap_armed = 0;
      end
    end
    prev_start = o_tx_start;
    if (auto_tx) begin
      if (busy && in_frame) begin
        if (tick) xmit_left--;
        if (xmit_left <= 0) begin
          busy = 0; in_frame = 0;
          if (exempt) exempt = 0; else fall_pending = 1;
        end
      end else if (busy) begin
        if (!stuck) busy = 0;
      end else if (stuck) begin
        busy = 1;
      end else if (o_tx_start) begin
        busy = 1; in_frame = 1;
        xmit_left = (frame_len != 0) ? frame_len : $urandom_range(1, 4);
      end
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1; wr_data = d;
    cycle();
    wr_en = 0;
  endtask

  task automatic drain(input int max_cycles);
    bit done;
    done = 0;
    wr_en = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      tick = ($urandom_range(0, 3) == 0);
      cycle();
      done = model_quiet() && !busy;
    end
    tick = 0;
    check("drain_done", done, 1);
  endtask

  initial begin
    int n;
    // reset
    rst = 1;
    repeat (3) cycle();
    rst = 0;
    check("rst_level", o_level, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_data", o_tx_data, 8'h00);

    // single byte latency and handshake
    push(8'hA5);
    check("t1_level_after_push", o_level, 1);
    check("t1_no_start_yet", o_tx_start, 0);
    cycle();
    check("t1_start", o_tx_start, 1);
    check("t1_data", o_tx_data, 8'hA5);
    check("t1_level_after_pop", o_level, 0);
    cycle();
    check("t1_start_held", o_tx_start, 1);
    busy = 1;
    cycle();
    check("t1_start_drop", o_tx_start, 0);
    in_frame = 1; xmit_left = 3; auto_tx = 1;
    drain(500);

    // fill with busy stuck high, overflow, ordered drain
    auto_tx = 0; busy = 1;
    for (int i = 1; i <= 16; i++) push(8'(i));
    check("t2_level_full", o_level, 16);
    check("t2_full", o_full, 1);
    check("t2_no_start", o_tx_start, 0);
    push(8'hFF);
    check("t2_ovf_set", o_overflow, 1);
    check("t2_level_after_drop", o_level, 16);
`ifdef UART_TXQ_OVF_STICKY_EN
    for (int i = 0; i < 100; i++) begin
      cycle();
      check("t6_ovf_sticky", o_overflow, 1);
    end
    ovf_clr = 1;
    cycle();
    ovf_clr = 0;
    check("t6_ovf_cleared", o_overflow, 0);
`else
    cycle();
    check("t6_ovf_pulse", o_overflow, 0);
`endif
    emit_q.delete();
    busy = 0; auto_tx = 1;
    drain(3000);
    check("t2_emit_count", emit_q.size(), 16);
    n = emit_q.size();
    for (int i = 0; i < 16 && i < n; i++) check("t2_emit_order", emit_q[i], i + 1);

    // push into full queue on the pop cycle
    auto_tx = 0; busy = 1;
    for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
    check("t3_level_full", o_level, 16);
    emit_q.delete();
    busy = 0;
    push(8'h55);
    check("t3_level_stays", o_level, 16);
    check("t3_start", o_tx_start, 1);
    auto_tx = 1;
    drain(3000);
    check("t3_emit_count", emit_q.size(), 17);
    if (emit_q.size() != 0) check("t3_last_byte", emit_q[emit_q.size() - 1], 8'h55);

    // two bytes with 10-tick frames: the gap follows each busy fall
    frame_len = 10;
    n = gap_checks;
    push(8'h11);
    push(8'h22);
    drain(3000);
    check("t4_gap_checked", gap_checks > n, 1);
    frame_len = 0;

    // reset while a frame is being issued
    auto_tx = 0; busy = 1;
    for (int i = 0; i < 6; i++) push(8'(8'h80 + i));
    busy = 0;
    cycle();
    check("t5_issue", o_tx_start, 1);
    rst = 1;
    cycle();
    rst = 0;
    check("t5_rst_start", o_tx_start, 0);
    check("t5_rst_level", o_level, 0);
    check("t5_rst_empty", o_empty, 1);
    emit_q.delete();
    auto_tx = 1;
    push(8'h3C);
    drain(500);
    check("t5_emit_count", emit_q.size(), 1);
    if (emit_q.size() != 0) check("t5_emit_byte", emit_q[0], 8'h3C);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      n = (i / 500) % 3;
      wr_en   = ($urandom_range(0, 99) < (n == 0 ? 20 : (n == 1 ? 60 : 95)));
      wr_data = 8'($urandom_range(0, 255));
      tick    = ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 49) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      stuck   = (i % 800 >= 300) && (i % 800 < 380);
      cycle();
    end
    rst = 0; ovf_clr = 0; stuck = 0;
    drain(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
